// File: rtl/rv_mc_ctrl.sv
// Multicycle RV32 control unit: Moore FSM sequencing fetch, decode, memory,
// ALU, branch, jump and LUI steps, with a sticky trap on unsupported encodings.
module rv_mc_ctrl #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [3:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_CMP = 4'b1010;
  localparam logic [3:0] ALU_MOV = 4'b1101;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   w_ready;
  logic   w_pc_write;
  logic   w_ir_write;
  logic   w_reg_write;
  logic   w_mem_read;
  logic   w_mem_write;

  assign w_ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_ILLEGAL) r_illegal <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_REG:            w_next = S_EXECR;
          OP_IMM:            w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_LUI:            w_next = S_LUI;
          default:           w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   w_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = w_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR,
      S_EXECI:    w_next = (funct3 == 3'b000) ? S_ALUWB : S_ILLEGAL;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = (funct3[2:1] == 2'b00) ? S_FETCH : S_ILLEGAL;
      S_JAL:      w_next = S_ALUWB;
      S_LUI:      w_next = S_ALUWB;
      S_ILLEGAL:  w_next = S_ILLEGAL;
      default:    w_next = S_ILLEGAL;
    endcase
  end

  always_comb begin
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = A_PC;
    alu_src_b   = B_RS2;
    result_src  = RES_ALUOUT;
    alu_op      = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        alu_src_b  = B_FOUR;
        result_src = RES_ALURESULT;
        w_ir_write = w_ready;
        w_pc_write = w_ready;
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
      end
      S_MEMADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
      end
      S_MEMREAD: begin
        w_mem_read = 1'b1;
        adr_src    = 1'b1;
      end
      S_MEMWB: begin
        result_src  = RES_RDATA;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_write = 1'b1;
        adr_src     = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = A_RS1;
        alu_op    = funct7b5 ? ALU_SUB : ALU_ADD;
      end
      S_EXECI: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
      end
      S_ALUWB:  w_reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = A_RS1;
        alu_op    = ALU_CMP;
        case (funct3)
          3'b000:  w_pc_write = zero;
          3'b001:  w_pc_write = ~zero;
          default: w_pc_write = 1'b0;
        endcase
      end
      S_JAL: begin
        alu_src_a  = A_OLDPC;
        alu_src_b  = B_FOUR;
        w_pc_write = 1'b1;
      end
      S_LUI: begin
        alu_src_b = B_IMM;
        alu_op    = ALU_MOV;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_LOAD, OP_IMM: imm_src = IMM_I;
      OP_STORE:        imm_src = IMM_S;
      OP_BRANCH:       imm_src = IMM_B;
      OP_JAL:          imm_src = IMM_J;
      OP_LUI:          imm_src = IMM_U;
      default:         imm_src = IMM_I;
    endcase
  end

  // Enables drop as soon as reset_n falls so an interrupted memory access is
  // never completed, even before the reset edge arrives.
  assign pc_write  = reset_n & w_pc_write;
  assign ir_write  = reset_n & w_ir_write;
  assign reg_write = reset_n & w_reg_write;
  assign mem_read  = reset_n & w_mem_read;
  assign mem_write = reset_n & w_mem_write;
  assign illegal   = r_illegal;
  assign state     = r_state;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Bench for rv_mc_ctrl: each instruction is expanded into its expected
// per-cycle control trace, then replayed against the DUT cycle by cycle.
module tb_rv_mc_ctrl;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [3:0] ADD = 4'b0100, SUB = 4'b0010, CMP = 4'b1010, MOV = 4'b1101;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write, adr_src, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_op, state;

  int n_checks = 0;
  int n_err    = 0;

  rv_mc_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .alu_op(alu_op), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // en = {pc_write, ir_write, reg_write, mem_read, mem_write}
  typedef struct {
    logic [3:0] st;
    logic [4:0] en;
    logic       adr;
    logic [1:0] a, b, rs;
    logic [3:0] op;
    logic       ill;
    logic       rdy;
    logic       z;
  } exp_t;

  exp_t exp_q[$];
  bit   ends_illegal;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] imm_of(input logic [6:0] opc);
    case (opc)
      OP_STORE:  return 3'b001;
      OP_BRANCH: return 3'b010;
      OP_JAL:    return 3'b011;
      OP_LUI:    return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] st, input logic [4:0] en, input logic adr,
                      input logic [1:0] a, input logic [1:0] b, input logic [1:0] rs,
                      input logic [3:0] op, input logic ill, input logic rdy, input logic z);
    exp_t e;
    e.st = st; e.en = en; e.adr = adr; e.a = a; e.b = b; e.rs = rs;
    e.op = op; e.ill = ill; e.rdy = rdy; e.z = z;
    exp_q.push_back(e);
  endtask

  task automatic trap_tail(input int n);
    for (int i = 0; i < n; i++)
      push(4'd15, 5'b00000, 1'b0, 2'b00, 2'b00, 2'b00, ADD, 1'b1, rbit(), rbit());
    ends_illegal = 1'b1;
  endtask

  // Expected cycle-by-cycle trace of one instruction, from fetch to its last step.
  task automatic build(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input int fw, input int mw, input logic z);
    exp_q.delete();
    ends_illegal = 1'b0;
    for (int i = 0; i < fw; i++)
      push(4'd0, 5'b00010, 1'b0, 2'b00, 2'b10, 2'b10, ADD, 1'b0, 1'b0, rbit());
    push(4'd0, 5'b11010, 1'b0, 2'b00, 2'b10, 2'b10, ADD, 1'b0, 1'b1, rbit());
    push(4'd1, 5'b00000, 1'b0, 2'b01, 2'b01, 2'b00, ADD, 1'b0, rbit(), rbit());
    case (opc)
      OP_LOAD, OP_STORE: begin
        push(4'd2, 5'b00000, 1'b0, 2'b10, 2'b01, 2'b00, ADD, 1'b0, rbit(), rbit());
        for (int i = 0; i <= mw; i++) begin
          if (opc == OP_LOAD)
            push(4'd3, 5'b00010, 1'b1, 2'b00, 2'b00, 2'b00, ADD, 1'b0, (i == mw), rbit());
          else
            push(4'd5, 5'b00001, 1'b1, 2'b00, 2'b00, 2'b00, ADD, 1'b0, (i == mw), rbit());
        end
        if (opc == OP_LOAD)
          push(4'd4, 5'b00100, 1'b0, 2'b00, 2'b00, 2'b01, ADD, 1'b0, rbit(), rbit());
      end
      OP_REG, OP_IMM: begin
        if (opc == OP_REG)
          push(4'd6, 5'b00000, 1'b0, 2'b10, 2'b00, 2'b00, f7 ? SUB : ADD, 1'b0, rbit(), rbit());
        else
          push(4'd7, 5'b00000, 1'b0, 2'b10, 2'b01, 2'b00, ADD, 1'b0, rbit(), rbit());
        if (f3 != 3'b000) trap_tail(3);
        else push(4'd8, 5'b00100, 1'b0, 2'b00, 2'b00, 2'b00, ADD, 1'b0, rbit(), rbit());
      end
      OP_BRANCH: begin
        logic taken;
        taken = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
        push(4'd9, {taken, 4'b0000}, 1'b0, 2'b10, 2'b00, 2'b00, CMP, 1'b0, rbit(), z);
        if (f3 > 3'b001) trap_tail(3);
      end
      OP_JAL: begin
        push(4'd10, 5'b10000, 1'b0, 2'b01, 2'b10, 2'b00, ADD, 1'b0, rbit(), rbit());
        push(4'd8, 5'b00100, 1'b0, 2'b00, 2'b00, 2'b00, ADD, 1'b0, rbit(), rbit());
      end
      OP_LUI: begin
        push(4'd11, 5'b00000, 1'b0, 2'b00, 2'b01, 2'b00, MOV, 1'b0, rbit(), rbit());
        push(4'd8, 5'b00100, 1'b0, 2'b00, 2'b00, 2'b00, ADD, 1'b0, rbit(), rbit());
      end
      default: trap_tail(12);
    endcase
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic replay(input string name, input int limit);
    int n;
    exp_t e;
    n = (limit < 0) ? exp_q.size() : limit;
    for (int i = 0; i < n; i++) begin
      e = exp_q[i];
      mem_ready = e.rdy;
      zero      = e.z;
      #1;
      check($sformatf("%s c%0d state", name, i), 32'(state), 32'(e.st));
      check($sformatf("%s c%0d enables", name, i),
            32'({pc_write, ir_write, reg_write, mem_read, mem_write}), 32'(e.en));
      check($sformatf("%s c%0d muxes", name, i),
            32'({adr_src, alu_src_a, alu_src_b, result_src}),
            32'({e.adr, e.a, e.b, e.rs}));
      check($sformatf("%s c%0d alu_op", name, i), 32'(alu_op), 32'(e.op));
      check($sformatf("%s c%0d imm_src", name, i), 32'(imm_src), 32'(imm_of(opcode)));
      check($sformatf("%s c%0d illegal", name, i), 32'(illegal), 32'(e.ill));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string name);
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    #1;
    check({name, " enables in reset"},
          32'({pc_write, ir_write, reg_write, mem_read, mem_write}), 32'd0);
    @(posedge clk);
    #1;
    check({name, " state after reset"}, 32'(state), 32'd0);
    check({name, " illegal after reset"}, 32'(illegal), 32'd0);
    check({name, " alu_op after reset"}, 32'(alu_op), 32'(ADD));
    reset_n = 1'b1;
  endtask

  task automatic instr(input string name, input logic [6:0] opc, input logic [2:0] f3,
                       input logic f7, input int fw, input int mw, input logic z);
    opcode = opc; funct3 = f3; funct7b5 = f7;
    build(opc, f3, f7, fw, mw, z);
    replay(name, -1);
    if (ends_illegal) do_reset(name);
  endtask

  int         sel, fw, mw;
  logic       rz, rf7;
  logic [2:0] rf3;

  initial begin
    reset_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("por state", 32'(state), 32'd0);
    check("por illegal", 32'(illegal), 32'd0);
    check("por alu_op", 32'(alu_op), 32'(ADD));
    check("por enables", 32'({pc_write, ir_write, reg_write, mem_read, mem_write}), 32'd0);
    reset_n = 1'b1;

    instr("add",  OP_REG,    3'b000, 1'b0, 0, 0, 1'b0);
    instr("sub",  OP_REG,    3'b000, 1'b1, 1, 0, 1'b0);
    instr("lw",   OP_LOAD,   3'b010, 1'b0, 0, 3, 1'b0);
    instr("sw",   OP_STORE,  3'b010, 1'b0, 2, 1, 1'b0);
    instr("beq",  OP_BRANCH, 3'b000, 1'b0, 0, 0, 1'b1);
    instr("bne",  OP_BRANCH, 3'b001, 1'b0, 0, 0, 1'b1);
    instr("bne0", OP_BRANCH, 3'b001, 1'b0, 0, 0, 1'b0);
    instr("lui",  OP_LUI,    3'b101, 1'b1, 0, 0, 1'b0);
    instr("jal",  OP_JAL,    3'b011, 1'b0, 0, 0, 1'b0);
    instr("addi", OP_IMM,    3'b000, 1'b1, 0, 0, 1'b0);
    instr("bad_op",  7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0);
    instr("execr_f3", OP_REG,    3'b001, 1'b0, 0, 0, 1'b0);
    instr("execi_f3", OP_IMM,    3'b111, 1'b0, 0, 0, 1'b0);
    instr("blt",      OP_BRANCH, 3'b100, 1'b0, 0, 0, 1'b1);

    // Reset lands while a store is still waiting on memory.
    opcode = OP_STORE; funct3 = 3'b010; funct7b5 = 1'b0;
    build(OP_STORE, 3'b010, 1'b0, 0, 5, 1'b0);
    replay("sw_rst", 4);
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("sw_rst state before edge", 32'(state), 32'd5);
    check("sw_rst mem_write in reset", 32'(mem_write), 32'd0);
    @(posedge clk);
    #1;
    check("sw_rst state after edge", 32'(state), 32'd0);
    reset_n = 1'b1;

    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 8);
      fw  = $urandom_range(0, 2);
      mw  = $urandom_range(0, 3);
      rz  = rbit();
      rf7 = rbit();
      rf3 = 3'($urandom_range(0, 7));
      case (sel)
        0: instr($sformatf("r%0d op", k),   OP_REG,    3'b000, rf7, fw, mw, rz);
        1: instr($sformatf("r%0d opi", k),  OP_IMM,    3'b000, rf7, fw, mw, rz);
        2: instr($sformatf("r%0d lw", k),   OP_LOAD,   rf3,    rf7, fw, mw, rz);
        3: instr($sformatf("r%0d sw", k),   OP_STORE,  rf3,    rf7, fw, mw, rz);
        4: instr($sformatf("r%0d br", k),   OP_BRANCH, {2'b00, rf3[0]}, rf7, fw, mw, rz);
        5: instr($sformatf("r%0d jal", k),  OP_JAL,    rf3,    rf7, fw, mw, rz);
        6: instr($sformatf("r%0d lui", k),  OP_LUI,    rf3,    rf7, fw, mw, rz);
        7: instr($sformatf("r%0d lw2", k),  OP_LOAD,   3'b010, rf7, fw, mw, rz);
        default: instr($sformatf("r%0d sub", k), OP_REG, 3'b000, 1'b1, fw, mw, rz);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rv_mc_ctrl.md
RV_MC_CTRL -- requirements
Module: rv_mc_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1, meaning: 1 = honour mem_ready; 0 = treat mem_ready as constantly 1.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port opcode  input  7  instr[6:0] from the instruction register.
REQ-005 SHALL have port funct3  input  3  instr[14:12].
REQ-006 SHALL have port funct7b5  input  1  instr[30].
REQ-007 SHALL have port zero  input  1  ALU flag bit 2 (ALUFlags[2]) from the CMP operation.
REQ-008 SHALL have port mem_ready  input  1  memory access done this cycle.
REQ-009 SHALL have outputs pc_write, ir_write, reg_write, mem_read, mem_write, adr_src, each output 1: write/read enables; adr_src 0 = PC, 1 = ALUOut.
REQ-010 SHALL have outputs alu_src_a and alu_src_b, each output 2: A 00 = PC, 01 = oldPC, 10 = rs1; B 00 = rs2, 01 = imm, 10 = const 4.
REQ-011 SHALL have output result_src  output  2  00 = ALUOut, 01 = read data, 10 = ALUResult.
REQ-012 SHALL have output imm_src  output  3  I = 000, S = 001, B = 010, J = 011, U = 100, decoded from opcode in every state; 000 for unknown opcodes.
REQ-013 SHALL have output alu_op  output  4  ADD = 0100, SUB = 0010, CMP = 1010, MOV = 1101.
REQ-014 SHALL have outputs illegal (output 1, sticky trap flag) and state (output 4, debug state code).

Function
REQ-015 SHALL be a Moore FSM with a 4-bit state register; outputs SHALL be combinational from state, plus funct3/funct7b5/zero/mem_ready where stated below.
REQ-016 SHALL use state codes FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11, ILLEGAL 15.
REQ-017 SHALL, in every state, default all enables to 0, alu_src_a/alu_src_b/result_src to 00, and alu_op to ADD unless a state overrides them.
REQ-018 SHALL, in FETCH: mem_read = 1, adr_src = 0, A = PC, B = 4, ADD, result_src = 10; ir_write = pc_write = mem_ready; stay in FETCH while !mem_ready, otherwise go to DECODE.
REQ-019 SHALL, in DECODE: A = oldPC, B = imm, ADD (branch/jump target into ALUOut); next state by opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, 0110111 -> LUI, any other -> ILLEGAL.
REQ-020 SHALL, in MEMADR: A = rs1, B = imm, ADD; opcode 0000011 -> MEMREAD, otherwise -> MEMWRITE.
REQ-021 SHALL, in MEMREAD: mem_read = 1, adr_src = 1; hold until mem_ready, then go to MEMWB.
REQ-022 SHALL, in MEMWB: result_src = 01, reg_write = 1, then go to FETCH.
REQ-023 SHALL, in MEMWRITE: mem_write = 1, adr_src = 1; hold until mem_ready, then go to FETCH.
REQ-024 SHALL, in EXECR: A = rs1, B = rs2; alu_op = SUB if funct7b5 = 1, else ADD; funct3 != 000 -> ILLEGAL, else -> ALUWB.
REQ-025 SHALL, in EXECI: A = rs1, B = imm, ADD; funct3 != 000 -> ILLEGAL, else -> ALUWB.
REQ-026 SHALL, in ALUWB: result_src = 00, reg_write = 1, then go to FETCH.
REQ-027 SHALL, in BRANCH: A = rs1, B = rs2, CMP, result_src = 00; pc_write = zero for funct3 000 and !zero for funct3 001; go to FETCH; any other funct3 -> ILLEGAL with pc_write = 0.
REQ-028 SHALL, in JAL: A = oldPC, B = 4, ADD, result_src = 00, pc_write = 1, then go to ALUWB.
REQ-029 SHALL, in LUI: B = imm, alu_op = MOV, then go to ALUWB.
REQ-030 SHALL, in ILLEGAL: illegal = 1, all enables 0, no exit except reset.
REQ-031 SHALL never assert mem_read and mem_write in the same cycle, nor pc_write outside FETCH/BRANCH/JAL.

Reset
REQ-032 SHALL load state = FETCH and clear illegal on a rising clk edge with reset_n = 0.
REQ-033 SHALL force all enables to 0 while reset_n = 0, including a reset asserted mid-MEMREAD/MEMWRITE; alu_op reads 0100 and state reads 0 from the first reset edge.

Verification
REQ-034 SHALL pass: add (0110011, f3 000, f7b5 0) with mem_ready = 1 -> states 0,1,6,8,0; alu_op in EXECR = 0100; reg_write = 1 only in cycle 4.
REQ-035 SHALL pass: lw with mem_ready low 3 cycles in MEMREAD -> states 0,1,2,3,3,3,3,4,0; mem_read = 1 and adr_src = 1 throughout MEMREAD.
REQ-036 SHALL pass: beq with zero = 1 -> pc_write = 1 and alu_op = 1010 in BRANCH; bne with zero = 1 -> pc_write = 0.
REQ-037 SHALL pass: opcode 1111111 -> DECODE then 15; illegal = 1 for 10+ cycles; reset_n low for 1 edge -> state = 0 and illegal = 0.
REQ-038 SHALL pass: lui -> alu_op = 1101 and alu_src_b = 01 in state 11, then ALUWB; jal -> pc_write = 1 in state 10, then reg_write = 1 in state 8.
REQ-039 SHALL pass: reset_n low during MEMWRITE -> mem_write = 0 in that cycle; state = 0 after the edge.
